// File: rtl/icache_ram_responder_pkg.sv
// Shared system-configuration macros (bus widths, booleans, responder state codes)
// and the package with the responder's state type and address/mask helpers.
`ifndef SYSCONFIG_V
`define SYSCONFIG_V
`define NPC_ADDR_BUS 31:0
`define XLEN_BUS     63:0
`define TRUE         1'b1
`define FALSE        1'b0
`define RSP_IDLE     2'd0
`define RSP_WAIT     2'd1
`define RSP_DATA     2'd2
`endif

package icache_ram_responder_pkg;

    typedef enum logic [1:0] {
        RSP_IDLE = `RSP_IDLE,
        RSP_WAIT = `RSP_WAIT,
        RSP_DATA = `RSP_DATA
    } rsp_state_t;

    function automatic logic [63:0] expand_mask(input logic [7:0] m);
        logic [63:0] full;
        for (int b = 0; b < 8; b++) begin
            full[8*b +: 8] = {8{m[b]}};
        end
        return full;
    endfunction

    // Below the base, or past the last word once the low three bits are dropped.
    function automatic logic addr_oob(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input int unsigned words);
        logic [31:0] off;
        off = addr - base;
        return (addr < base) || ((off >> 3) >= 32'(words));
    endfunction

endpackage

// File: rtl/icache_ram_array.sv
// Word-addressed 64-bit storage: one synchronous read port, one byte-masked write port.
module icache_ram_array #(
    parameter int unsigned WORDS = 1024,
    parameter int          IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [63:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [63:0]      wr_data,
    input  logic [7:0]       wr_mask
);

    logic [63:0] mem [WORDS];

    // Only the read register is reset; the contents survive reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/icache_ram_responder.sv
// Memory-side responder for the icache refill port: fixed-latency reads from a local
// RAM with a one-cycle ready pulse, plus a byte-masked preload port and status.
module icache_ram_responder
    import icache_ram_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [`NPC_ADDR_BUS] ram_raddr_icache_i,
    input  logic                 ram_raddr_valid_icache_i,
    input  logic [7:0]           ram_rmask_icache_i,
    output logic                 ram_rdata_ready_icache_o,
    output logic [`XLEN_BUS]     ram_rdata_icache_o,
    input  logic                 mem_wen_i,
    input  logic [`NPC_ADDR_BUS] mem_waddr_i,
    input  logic [`XLEN_BUS]     mem_wdata_i,
    input  logic [7:0]           mem_wmask_i,
    output logic                 err_o,
    output logic [31:0]          beat_cnt_o
);

    localparam int         IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    rsp_state_t       state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] in_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       req_mask;
    logic [7:0]       beat_mask;
    logic             req_oob;
    logic             in_oob;
    logic             wr_oob;
    logic             rd_en;
    logic             wr_en;
    logic             ready;
    logic             err;
    logic [31:0]      beat_cnt;
    logic [63:0]      rd_word;

    assign in_idx = IDX_W'((ram_raddr_icache_i - BASE_ADDR) >> 3);
    assign wr_idx = IDX_W'((mem_waddr_i - BASE_ADDR) >> 3);
    assign in_oob = addr_oob(ram_raddr_icache_i, BASE_ADDR, MEM_WORDS);
    assign wr_oob = addr_oob(mem_waddr_i, BASE_ADDR, MEM_WORDS);
    assign wr_en  = mem_wen_i && !wr_oob;

    // The array read fires on the edge entering RSP_DATA; with a latency of one that
    // edge is the acceptance edge, so the index comes straight from the request.
    always_comb begin
        rd_en  = 1'b0;
        rd_idx = req_idx;
        if (state == RSP_IDLE && ram_raddr_valid_icache_i && LAT_M1 == 4'd0) begin
            rd_en  = 1'b1;
            rd_idx = in_idx;
        end else if (state == RSP_WAIT && cnt == 4'd1) begin
            rd_en = 1'b1;
        end
    end

    icache_ram_array #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (rd_en),
        .rd_idx  (rd_idx),
        .rd_data (rd_word),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (mem_wdata_i),
        .wr_mask (mem_wmask_i)
    );

    // beat_mask is captured alongside the array word, so an out-of-range beat reads 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RSP_IDLE;
            cnt       <= 4'd0;
            req_idx   <= '0;
            req_mask  <= 8'd0;
            req_oob   <= `FALSE;
            beat_mask <= 8'd0;
            ready     <= `FALSE;
            err       <= `FALSE;
            beat_cnt  <= 32'd0;
        end else begin
            ready <= `FALSE;
            case (state)
                RSP_IDLE: begin
                    if (ram_raddr_valid_icache_i) begin
                        req_idx  <= in_idx;
                        req_mask <= ram_rmask_icache_i;
                        req_oob  <= in_oob;
                        cnt      <= LAT_M1;
                        if (in_oob) err <= `TRUE;
                        if (LAT_M1 != 4'd0) begin
                            state <= RSP_WAIT;
                        end else begin
                            state     <= RSP_DATA;
                            ready     <= `TRUE;
                            beat_mask <= in_oob ? 8'd0 : ram_rmask_icache_i;
                        end
                    end
                end
                RSP_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RSP_DATA;
                        ready     <= `TRUE;
                        beat_mask <= req_oob ? 8'd0 : req_mask;
                    end
                end
                RSP_DATA: begin
                    state    <= RSP_IDLE;
                    beat_cnt <= beat_cnt + 32'd1;
                end
                default: state <= RSP_IDLE;
            endcase
            if (mem_wen_i && wr_oob) err <= `TRUE;
        end
    end

    assign ram_rdata_ready_icache_o = ready;
    assign ram_rdata_icache_o       = rd_word & expand_mask(beat_mask);
    assign err_o                    = err;
    assign beat_cnt_o               = beat_cnt;

endmodule

// File: tb/tb_icache_ram_responder.sv
// Directed bench for icache_ram_responder: one instance at LATENCY=2 and one at
// LATENCY=1 share the same stimulus; each scenario checks its own outputs inline.
module tb_icache_ram_responder;
    import icache_ram_responder_pkg::*;

    localparam logic [63:0] WORD0 = 64'h0011_2233_4455_6677;
    localparam logic [63:0] WORD1 = 64'h8899_AABB_CCDD_EEFF;
    localparam logic [63:0] BEEF  = 64'hDEAD_BEEF_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] raddr;
    logic        rvalid;
    logic [7:0]  rmask;
    logic        wen;
    logic [31:0] waddr;
    logic [63:0] wdata;
    logic [7:0]  wmask;

    logic        rdy2, err2, rdy1, err1;
    logic [63:0] data2, data1;
    logic [31:0] cnt2, cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_ram_responder #(.MEM_WORDS(1024), .LATENCY(2), .BASE_ADDR(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .ram_raddr_icache_i(raddr), .ram_raddr_valid_icache_i(rvalid), .ram_rmask_icache_i(rmask),
        .ram_rdata_ready_icache_o(rdy2), .ram_rdata_icache_o(data2),
        .mem_wen_i(wen), .mem_waddr_i(waddr), .mem_wdata_i(wdata), .mem_wmask_i(wmask),
        .err_o(err2), .beat_cnt_o(cnt2)
    );

    icache_ram_responder #(.MEM_WORDS(1024), .LATENCY(1), .BASE_ADDR(32'h8000_0000)) dut1 (
        .clk(clk), .rst(rst),
        .ram_raddr_icache_i(raddr), .ram_raddr_valid_icache_i(rvalid), .ram_rmask_icache_i(rmask),
        .ram_rdata_ready_icache_o(rdy1), .ram_rdata_icache_o(data1),
        .mem_wen_i(wen), .mem_waddr_i(waddr), .mem_wdata_i(wdata), .mem_wmask_i(wmask),
        .err_o(err1), .beat_cnt_o(cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic preload(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        wen = 1'b1; waddr = a; wdata = d; wmask = m;
        tick();
        wen = 1'b0;
    endtask

    // Valid is held for exactly the acceptance edge, then dropped.
    task automatic read_req(input logic [31:0] a, input logic [7:0] m);
        raddr = a; rmask = m; rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %0b want 0", rdy2); end
        checks++; if (data2 !== 64'd0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", data2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b want 0", err2); end
        checks++; if (cnt2 !== 32'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", cnt2); end
        checks++; if (dut.state !== RSP_IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d want %0d", dut.state, RSP_IDLE); end
    endtask

    task automatic test_refill();
        preload(32'h8000_0000, WORD0, 8'hFF);
        preload(32'h8000_0008, WORD1, 8'hFF);
        raddr = 32'h8000_0000; rmask = 8'hFF; rvalid = 1'b1;
        tick();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL refill_e1_ready got %0b want 0", rdy2); end
        tick();
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL refill_e2_ready got %0b want 1", rdy2); end
        checks++; if (data2 !== WORD0) begin errors++; $display("[TB] FAIL refill_beat0 got %h want %h", data2, WORD0); end
        raddr = 32'h8000_0008;
        tick();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL refill_e3_ready got %0b want 0", rdy2); end
        checks++; if (data2 !== WORD0) begin errors++; $display("[TB] FAIL refill_hold got %h want %h", data2, WORD0); end
        tick();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL refill_e4_ready got %0b want 0", rdy2); end
        tick();
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL refill_e5_ready got %0b want 1", rdy2); end
        checks++; if (data2 !== WORD1) begin errors++; $display("[TB] FAIL refill_beat1 got %h want %h", data2, WORD1); end
        rvalid = 1'b0;
        tick();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL refill_end_ready got %0b want 0", rdy2); end
        checks++; if (cnt2 !== 32'd2) begin errors++; $display("[TB] FAIL refill_beat_cnt got %0d want 2", cnt2); end
        tick();
    endtask

    task automatic test_mask_latency1();
        read_req(32'h8000_0004, 8'h0F);
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("[TB] FAIL lat1_ready got %0b want 1", rdy1); end
        checks++; if (data1 !== 64'h0000_0000_4455_6677) begin errors++; $display("[TB] FAIL lat1_mask_data got %h want 0000000044556677", data1); end
        tick();
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("[TB] FAIL lat1_single_pulse got %0b want 0", rdy1); end
        checks++; if (data1 !== 64'h0000_0000_4455_6677) begin errors++; $display("[TB] FAIL lat1_hold got %h want 0000000044556677", data1); end
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL lat2_mask_ready got %0b want 1", rdy2); end
        checks++; if (data2 !== 64'h0000_0000_4455_6677) begin errors++; $display("[TB] FAIL lat2_mask_data got %h want 0000000044556677", data2); end
        tick();
        tick();
    endtask

    task automatic test_out_of_range();
        read_req(32'h7FFF_FFF8, 8'hFF);
        tick();
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_low_ready got %0b want 1", rdy2); end
        checks++; if (data2 !== 64'd0) begin errors++; $display("[TB] FAIL oob_low_data got %h want 0", data2); end
        checks++; if (err2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_low_err got %0b want 1", err2); end
        tick();
        tick();
        checks++; if (err2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_err_sticky got %0b want 1", err2); end
        do_reset();
        checks++; if (err2 !== 1'b0) begin errors++; $display("[TB] FAIL oob_err_cleared got %0b want 0", err2); end
        read_req(32'h8000_2000, 8'hFF);
        tick();
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_high_ready got %0b want 1", rdy2); end
        checks++; if (data2 !== 64'd0) begin errors++; $display("[TB] FAIL oob_high_data got %h want 0", data2); end
        checks++; if (err2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_high_err got %0b want 1", err2); end
        tick();
        read_req(32'h8000_0008, 8'hFF);
        tick();
        checks++; if (data2 !== WORD1) begin errors++; $display("[TB] FAIL oob_then_good got %h want %h", data2, WORD1); end
        checks++; if (err2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_err_held got %0b want 1", err2); end
        tick();
        do_reset();
        // Index 1024 aliases word 0 after truncation, so a leaked write would corrupt it.
        preload(32'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        checks++; if (err2 !== 1'b1) begin errors++; $display("[TB] FAIL oob_write_err got %0b want 1", err2); end
        read_req(32'h8000_0000, 8'hFF);
        tick();
        checks++; if (data2 !== WORD0) begin errors++; $display("[TB] FAIL oob_write_dropped got %h want %h", data2, WORD0); end
        tick();
    endtask

    task automatic test_drop_valid();
        read_req(32'h8000_0008, 8'hFF);
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL drop_e1_ready got %0b want 0", rdy2); end
        checks++; if (dut.state !== RSP_WAIT) begin errors++; $display("[TB] FAIL drop_e1_state got %0d want %0d", dut.state, RSP_WAIT); end
        tick();
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL drop_ready got %0b want 1", rdy2); end
        checks++; if (data2 !== WORD1) begin errors++; $display("[TB] FAIL drop_data got %h want %h", data2, WORD1); end
        tick();
        checks++; if (dut.state !== RSP_IDLE) begin errors++; $display("[TB] FAIL drop_idle got %0d want %0d", dut.state, RSP_IDLE); end
        tick();
        tick();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL drop_no_extra_beat got %0b want 0", rdy2); end
        checks++; if (dut.state !== RSP_IDLE) begin errors++; $display("[TB] FAIL drop_still_idle got %0d want %0d", dut.state, RSP_IDLE); end
    endtask

    task automatic test_same_edge_write();
        read_req(32'h8000_0000, 8'hFF);
        wen = 1'b1; waddr = 32'h8000_0000; wdata = BEEF; wmask = 8'hFF;
        tick();
        wen = 1'b0;
        checks++; if (rdy2 !== 1'b1) begin errors++; $display("[TB] FAIL same_edge_ready got %0b want 1", rdy2); end
        checks++; if (data2 !== WORD0) begin errors++; $display("[TB] FAIL same_edge_old_data got %h want %h", data2, WORD0); end
        tick();
        read_req(32'h8000_0000, 8'hFF);
        tick();
        checks++; if (data2 !== BEEF) begin errors++; $display("[TB] FAIL same_edge_new_data got %h want %h", data2, BEEF); end
        tick();
    endtask

    task automatic test_reset_mid();
        // Four beats have completed since the last reset (oob re-read, drop, two same-edge reads).
        checks++; if (cnt2 !== 32'd4) begin errors++; $display("[TB] FAIL beat_cnt_before_reset got %0d want 4", cnt2); end
        read_req(32'h8000_0008, 8'hFF);
        checks++; if (dut.state !== RSP_WAIT) begin errors++; $display("[TB] FAIL mid_in_wait got %0d want %0d", dut.state, RSP_WAIT); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_ready got %0b want 0", rdy2); end
        checks++; if (data2 !== 64'd0) begin errors++; $display("[TB] FAIL mid_reset_data got %h want 0", data2); end
        checks++; if (dut.state !== RSP_IDLE) begin errors++; $display("[TB] FAIL mid_reset_state got %0d want %0d", dut.state, RSP_IDLE); end
        checks++; if (cnt2 !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_cnt got %0d want 0", cnt2); end
        tick();
        tick();
        checks++; if (rdy2 !== 1'b0) begin errors++; $display("[TB] FAIL mid_beat_discarded got %0b want 0", rdy2); end
        read_req(32'h8000_0000, 8'hFF);
        tick();
        checks++; if (data2 !== BEEF) begin errors++; $display("[TB] FAIL post_reset_word0 got %h want %h", data2, BEEF); end
        tick();
        read_req(32'h8000_0008, 8'hFF);
        tick();
        checks++; if (data2 !== WORD1) begin errors++; $display("[TB] FAIL post_reset_word1 got %h want %h", data2, WORD1); end
        tick();
    endtask

    initial begin
        rst = 1'b0; raddr = 32'd0; rvalid = 1'b0; rmask = 8'd0;
        wen = 1'b0; waddr = 32'd0; wdata = 64'd0; wmask = 8'd0;
        test_reset();
        test_refill();
        test_mask_latency1();
        test_out_of_range();
        test_drop_valid();
        test_same_edge_write();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
